countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl.sv | 105 ++++++++++
 tb/tb_countdown_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Sequences an external 4-bit down-counter from 15 toward a latched target,
// shadowing its value every cycle and flagging any divergence.
module countdown_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] target,
  input  logic       tick,
  input  logic       abort,
  input  logic [3:0] counter,
  output logic       clear,
  output logic       set,
  output logic       cnt,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [3:0] expected
);

  // state | meaning
  // IDLE  | waiting for start
  // CLR   | responder being cleared to 15
  // RUN   | compare responder, decrement toward target on tick
  // DONE  | one-cycle completion pulse
  // ERR   | responder diverged; wait for abort or reset
  // PARK  | responder being set to 0
  typedef enum logic [2:0] {IDLE, CLR, RUN, DONE, ERR, PARK} state_t;

  state_t     state, state_nxt;
  logic [3:0] target_q, target_nxt, expected_nxt;
  logic       mismatch_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      target_q <= 4'd0;
      expected <= 4'hF;
      mismatch <= 1'b0;
    end else begin
      state    <= state_nxt;
      target_q <= target_nxt;
      expected <= expected_nxt;
      mismatch <= mismatch_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    target_nxt   = target_q;
    expected_nxt = expected;
    mismatch_nxt = mismatch;
    clear        = 1'b0;
    set          = 1'b0;
    cnt          = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = CLR;
          target_nxt   = target;
          mismatch_nxt = 1'b0;
        end
      end
      CLR: begin
        if (abort) begin
          state_nxt = PARK;
        end else begin
          clear        = 1'b1;
          state_nxt    = RUN;
          expected_nxt = 4'hF;
        end
      end
      RUN: begin
        // abort outranks the compare, which outranks completion and tick
        if (abort) begin
          state_nxt = PARK;
        end else if (counter != expected) begin
          mismatch_nxt = 1'b1;
          state_nxt    = ERR;
        end else if (expected == target_q) begin
          state_nxt = DONE;
        end else if (tick) begin
          cnt          = 1'b1;
          expected_nxt = expected - 4'd1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = abort ? PARK : IDLE;
      end
      ERR: begin
        if (abort) state_nxt = PARK;
      end
      PARK: begin
        set          = 1'b1;
        expected_nxt = 4'd0;
        mismatch_nxt = 1'b0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: stimulus pushes expected done/set/error
// events, a negedge monitor pops and checks them against an ideal responder.
module tb_countdown_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] target = 4'd0;
  logic [3:0] counter = 4'd5;
  logic       hold14 = 1'b0;
  logic       clear, set, cnt, busy, done, mismatch;
  logic [3:0] expected;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int tot_cnt = 0;
  int tot_clr = 0;

  // kind: 0 = done, 1 = set, 2 = mismatch rising
  typedef struct {
    int kind; int n0; int cnt0; int clr0;
    int lat; int expv; int ctr; int np; int nc; int mis;
  } ev_t;
  ev_t sbq[$];
  ev_t ev;
  int  kind;
  bit  mis_prev = 1'b0;

  countdown_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .target(target),
    .tick(tick), .abort(abort), .counter(counter),
    .clear(clear), .set(set), .cnt(cnt), .busy(busy), .done(done),
    .mismatch(mismatch), .expected(expected)
  );

  always #5 clock = ~clock;

  // responder; hold14 makes it refuse to step below 14
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (clear === 1'b1) counter <= 4'hF;
    else if (set === 1'b1) counter <= 4'd0;
    else if (cnt === 1'b1 && !(hold14 && counter == 4'd14)) counter <= counter - 4'd1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (cnt === 1'b1) tot_cnt++;
    if (clear === 1'b1) tot_clr++;
    if (done === 1'b1 || set === 1'b1 || (mismatch === 1'b1 && !mis_prev)) begin
      kind = (done === 1'b1) ? 0 : (set === 1'b1) ? 1 : 2;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=kind%0d required=none (cycle %0d)", kind, cyc);
      end else begin
        ev = sbq.pop_front();
        chk("ev_kind", kind, ev.kind);
        chk("ev_latency", cyc + 1 - ev.n0, ev.lat);
        chk("ev_expected", int'(expected), ev.expv);
        chk("ev_counter", int'(counter), ev.ctr);
        chk("ev_cnt_pulses", tot_cnt - ev.cnt0, ev.np);
        chk("ev_clear_pulses", tot_clr - ev.clr0, ev.nc);
        chk("ev_mismatch", int'(mismatch), ev.mis);
      end
    end
    mis_prev = (mismatch === 1'b1);
  end

  task automatic push(input int k, input int n, input int lat, input int expv,
                      input int ctr, input int np, input int mis);
    ev_t e;
    e.kind = k; e.n0 = n; e.cnt0 = tot_cnt; e.clr0 = tot_clr;
    e.lat = lat; e.expv = expv; e.ctr = ctr; e.np = np; e.nc = 1; e.mis = mis;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] tgt);
    target = tgt;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic drain(input int maxc, input bit alt, input int n);
    for (int i = 0; i < maxc && sbq.size() != 0; i++) begin
      if (alt) tick = ((cyc - n) % 2 == 0);
      step();
    end
    chk("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int clr_snap;

    reset = 1'b1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", clear, 0);
    chk("rst_set", set, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_expected", expected, 15);
    reset = 1'b0;
    step();

    // abort while idle must not park
    abort = 1'b1;
    step();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_set", set, 0);
    abort = 1'b0;
    step();
    chk("idle_abort_set2", set, 0);

    // target 12, continuous tick
    tick = 1'b1;
    n = cyc + 1;
    push(0, n, 6, 12, 12, 3, 0);
    pulse_start(4'd12);
    drain(60, 1'b0, n);
    chk("t12_busy_after", busy, 0);
    chk("t12_expected_hold", expected, 12);

    // target 15: no decrements at all
    n = cyc + 1;
    push(0, n, 3, 15, 15, 0, 0);
    pulse_start(4'd15);
    drain(60, 1'b0, n);

    // target 0 with tick alternating, starting low in the first RUN cycle
    n = cyc + 1;
    push(0, n, 33, 0, 0, 15, 0);
    pulse_start(4'd0);
    drain(80, 1'b1, n);
    chk("t0_counter", counter, 0);
    tick = 1'b1;

    // responder sticks at 14 while expected moves to 13
    hold14 = 1'b1;
    n = cyc + 1;
    push(2, n, 5, 13, 14, 2, 1);
    push(1, n, 9, 13, 14, 2, 1);
    pulse_start(4'd0);
    repeat (5) step();
    chk("err_mismatch", mismatch, 1);
    chk("err_busy", busy, 1);
    chk("err_cnt", cnt, 0);
    chk("err_clear", clear, 0);
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("err_park_set", set, 1);
    step();
    chk("err_after_busy", busy, 0);
    chk("err_after_mismatch", mismatch, 0);
    chk("err_after_expected", expected, 0);
    chk("err_after_counter", counter, 0);
    hold14 = 1'b0;

    // abort together with tick at expected 9
    n = cyc + 1;
    push(1, n, 9, 9, 9, 6, 0);
    pulse_start(4'd0);
    repeat (7) step();
    abort = 1'b1;
    #1;
    chk("abort_cnt", cnt, 0);
    chk("abort_expected", expected, 9);
    chk("abort_clear", clear, 0);
    step();
    abort = 1'b0;
    step();
    chk("abort_counter", counter, 0);
    chk("abort_expected_after", expected, 0);
    chk("abort_busy_after", busy, 0);

    // reset mid-run at expected 7, with start and abort also high
    pulse_start(4'd0);
    repeat (9) step();
    chk("rr_expected_pre", expected, 7);
    clr_snap = tot_clr;
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    step();
    chk("rr_busy", busy, 0);
    chk("rr_expected", expected, 15);
    chk("rr_clear", clear, 0);
    chk("rr_set", set, 0);
    chk("rr_cnt", cnt, 0);
    chk("rr_done", done, 0);
    chk("rr_mismatch", mismatch, 0);
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    step();
    chk("rr_busy_after", busy, 0);
    chk("rr_no_clear", tot_clr - clr_snap, 0);

    // start and a new target while busy must be ignored
    n = cyc + 1;
    push(0, n, 6, 12, 12, 3, 0);
    pulse_start(4'd12);
    start  = 1'b1;
    target = 4'd3;
    repeat (4) step();
    start = 1'b0;
    drain(60, 1'b0, n);
    chk("busy_start_idle", busy, 0);

    step();
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
